// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - mode encodings shared by the register, its parents and benches
package shift_register_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_CLR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_SHR  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ROR  = 3'b111;

endpackage

// File: rtl/usr_cell.sv
// rtl/usr_cell.sv - one bit of the universal shift register: next-state mux plus async-reset flop
module usr_cell
  import shift_register_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       d,
  input  logic       shl_in,
  input  logic       shr_in,
  output logic       q
);

  logic q_d;
  logic q_q;

  // en is tested before mode so an unknown mode while disabled cannot leak into q
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = d;
        MODE_CLR:  q_d = 1'b0;
        MODE_SHL:  q_d = shl_in;
        MODE_SHR:  q_d = shr_in;
        MODE_ASR:  q_d = shr_in;
        MODE_ROL:  q_d = shl_in;
        MODE_ROR:  q_d = shr_in;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_register_universal.sv
// rtl/shift_register_universal.sv - WIDTH-bit hold/load/clear/shift/rotate register with serial chaining ends
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero
);

  logic             edge_l;
  logic             edge_r;
  logic [WIDTH-1:0] shl_in;
  logic [WIDTH-1:0] shr_in;

  // Only the two end cells care about the mode: wrap bit, sign bit or serial input
  always_comb begin
    edge_l = sin_l;
    if (mode == MODE_ROL) begin
      edge_l = Q[WIDTH-1];
    end
    edge_r = sin_r;
    if (mode == MODE_ROR) begin
      edge_r = Q[0];
    end else if (mode == MODE_ASR) begin
      edge_r = Q[WIDTH-1];
    end
    shl_in = {Q[WIDTH-2:0], edge_l};
    shr_in = {edge_r, Q[WIDTH-1:1]};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .d      (D[i]),
      .shl_in (shl_in[i]),
      .shr_in (shr_in[i]),
      .q      (Q[i])
    );
  end

  assign nQ     = ~Q;
  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];
  assign zero   = (Q == '0);

endmodule

// File: tb/tb_shift_register_universal.sv
// tb/tb_shift_register_universal.sv - directed and randomized checks of shift_register_universal, single and chained
module tb_shift_register_universal;
  import shift_register_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d0, d1;
  logic       sl0, sl1_ext, sr0_ext, sr1;
  logic       chain;
  logic       sl1, sr0;
  logic [7:0] q0, nq0, q1, nq1;
  logic       sol0, sor0, z0, sol1, sor1, z1;

  int checks = 0;
  int errors = 0;

  always #42 clk = ~clk;

  assign sl1 = chain ? sol0 : sl1_ext;
  assign sr0 = chain ? sor1 : sr0_ext;

  shift_register_universal #(.WIDTH(8), .RST_VAL(8'h00)) u_lo (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d0), .sin_l(sl0), .sin_r(sr0),
    .Q(q0), .nQ(nq0), .sout_l(sol0), .sout_r(sor0), .zero(z0)
  );

  shift_register_universal #(.WIDTH(8), .RST_VAL(8'h00)) u_hi (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d1), .sin_l(sl1), .sin_r(sr1),
    .Q(q1), .nQ(nq1), .sout_l(sol1), .sout_r(sor1), .zero(z1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour in plain arithmetic on the register value
  function automatic logic [7:0] model(input logic [7:0] q, input logic [2:0] m,
                                       input logic [7:0] d, input logic sl, input logic sr);
    logic signed [7:0] s;
    logic [7:0] r;
    s = q;
    case (m)
      MODE_LOAD: r = d;
      MODE_CLR:  r = 8'd0;
      MODE_SHL:  r = 8'((q * 2) + sl);
      MODE_SHR:  r = 8'((q / 2) + (sr ? 128 : 0));
      MODE_ASR:  r = 8'(s >>> 1);
      MODE_ROL:  r = 8'((q * 2) + (q / 128));
      MODE_ROR:  r = 8'((q / 2) + ((q % 2) * 128));
      default:   r = q;
    endcase
    return r;
  endfunction

  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] da,
                      input logic [7:0] db, input logic sl, input logic sr);
    en = e; mode = m; d0 = da; d1 = db;
    sl0 = sl; sl1_ext = sl; sr0_ext = sr; sr1 = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [7:0] exp);
    chk(tag, {q0, nq0}, {exp, ~exp});
    chk(tag, {13'd0, sol0, sor0, z0}, {13'd0, exp[7], exp[0], exp == 8'd0});
  endtask

  logic [7:0]  exp0;
  logic [15:0] e16;
  logic        re;
  logic [2:0]  rm;
  logic [7:0]  rd0, rd1;
  logic        rsl, rsr;

  initial begin
    rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d0 = '0; d1 = '0;
    sl0 = 0; sl1_ext = 0; sr0_ext = 0; sr1 = 0; chain = 1'b0;
    #5;
    check_flags("reset_state", 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1 async reset between edges
    step(1, MODE_LOAD, 8'hA5, 8'h00, 0, 0);
    chk("load_a5", {8'd0, q0}, 16'h00A5);
    #20; rst = 1'b1; #1;
    check_flags("async_rst", 8'h00);
    step(1, MODE_LOAD, 8'h77, 8'h00, 0, 0);
    chk("rst_held", {8'd0, q0}, 16'h0000);
    rst = 1'b0;

    // 2 load then disabled hold, including unknown mode
    step(1, MODE_LOAD, 8'h3C, 8'h00, 0, 0);
    chk("load_3c", {8'd0, q0}, 16'h003C);
    for (int i = 0; i < 3; i++) step(0, MODE_LOAD, 8'hFF, 8'hFF, 1, 1);
    chk("en0_hold", {8'd0, q0}, 16'h003C);
    step(0, 3'bxxx, 8'hFF, 8'hFF, 1, 1);
    chk("en0_xmode", {8'd0, q0}, 16'h003C);

    // 3 shifts
    step(1, MODE_LOAD, 8'h81, 8'h00, 0, 0);
    chk("sout_l_pre", {15'd0, sol0}, 16'd1);
    step(1, MODE_SHL, 8'h00, 8'h00, 0, 0);
    chk("shl", {8'd0, q0}, 16'h0002);
    step(1, MODE_SHR, 8'h00, 8'h00, 0, 1);
    chk("shr", {8'd0, q0}, 16'h0081);
    step(1, MODE_ASR, 8'h00, 8'h00, 0, 0);
    chk("asr", {8'd0, q0}, 16'h00C0);

    // 4 rotates
    step(1, MODE_LOAD, 8'h96, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) step(1, MODE_ROL, 8'h00, 8'h00, 0, 0);
    chk("rol8", {8'd0, q0}, 16'h0096);
    step(1, MODE_ROR, 8'h00, 8'h00, 1, 1);
    chk("ror1", {8'd0, q0}, 16'h004B);
    step(1, MODE_ROL, 8'h00, 8'h00, 0, 0);
    chk("rol1", {8'd0, q0}, 16'h0096);

    // 5 clear and saturation
    step(1, MODE_LOAD, 8'h01, 8'h00, 0, 0);
    step(1, MODE_CLR, 8'hFF, 8'h00, 1, 1);
    check_flags("clr", 8'h00);
    step(1, MODE_LOAD, 8'h80, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) step(1, MODE_ASR, 8'h00, 8'h00, 0, 0);
    check_flags("asr_neg_sat", 8'hFF);
    for (int i = 0; i < 8; i++) step(1, MODE_SHR, 8'h00, 8'h00, 1, 0);
    check_flags("shr_drain", 8'h00);
    step(1, MODE_LOAD, 8'h7F, 8'h00, 0, 0);
    for (int i = 0; i < 7; i++) step(1, MODE_ASR, 8'h00, 8'h00, 0, 1);
    check_flags("asr_pos_sat", 8'h00);

    // randomized single-register operations
    exp0 = q0;
    for (int n = 0; n < 400; n++) begin
      re = ($urandom_range(0, 3) != 0);
      rm = 3'($urandom_range(0, 7));
      rd0 = 8'($urandom); rsl = 1'($urandom); rsr = 1'($urandom);
      if (re) exp0 = model(exp0, rm, rd0, rsl, rsr);
      step(re, rm, rd0, 8'($urandom), rsl, rsr);
      check_flags("rand", exp0);
    end

    // 6 chained pair acting as one 16-bit register
    chain = 1'b1;
    step(1, MODE_LOAD, 8'h01, 8'h80, 0, 0);
    step(1, MODE_SHL, 8'h00, 8'h00, 0, 0);
    chk("chain_shl", {q1, q0}, 16'h0002);
    e16 = 16'h0002;
    for (int n = 0; n < 150; n++) begin
      re = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0:       rm = MODE_LOAD;
        1, 2:    rm = MODE_SHL;
        3, 4:    rm = MODE_SHR;
        default: rm = MODE_HOLD;
      endcase
      rd0 = 8'($urandom); rd1 = 8'($urandom); rsl = 1'($urandom); rsr = 1'($urandom);
      if (re) begin
        if (rm == MODE_LOAD)     e16 = {rd1, rd0};
        else if (rm == MODE_SHL) e16 = 16'((e16 * 2) + rsl);
        else if (rm == MODE_SHR) e16 = 16'((e16 / 2) + (rsr ? 32768 : 0));
      end
      step(re, rm, rd0, rd1, rsl, rsr);
      chk("chain_rand", {q1, q0}, e16);
    end
    step(1, MODE_LOAD, 8'h01, 8'h80, 0, 0);
    step(1, MODE_SHL, 8'h00, 8'h00, 1, 0);
    #30; rst = 1'b1; #1;
    chk("chain_rst", {q1, q0}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, MODE_SHL, 8'h00, 8'h00, 1, 0);
    chk("chain_resume", {q1, q0}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
